seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display built around the team's single BCD-to-seven-segment decoder (LT/BI/RBI inputs, active-low segments). The controller holds a frame of BCD digits, walks them most-significant first, drives the decoder's D,C,B,A and control inputs for the active digit, and enables that digit's anode. It emulates ripple-blanking leading-zero suppression across the multiplexed digits and swaps in new data only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg7_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display driven through a BCD decoder.
// Walks the digits MSB first and emulates ripple-blanking across digits. New data is applied only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int ON_CYC  = 1000,
  parameter int GAP_CYC = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic                  lz_en_i,
  input  logic                  lt_req_i,
  input  logic                  blank_i,
  output logic                  d_o,
  output logic                  c_o,
  output logic                  b_o,
  output logic                  a_o,
  output logic                  lt_o,
  output logic                  bi_o,
  output logic                  rbi_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic                  frame_o
);
  localparam int MAXC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                zrun_q, zrun_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] stage_q, stage_d;
  logic [3:0]          dcba_q, dcba_d;
  logic                lt_q, lt_d, bi_q, bi_d, rbi_q, rbi_d, frame_q, frame_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [3:0]          cur_nib, nxt_nib;
  logic                show_end, boundary;

  assign cur_nib  = shadow_q[{idx_q, 2'b00} +: 4];
  assign show_end = (state_q == SHOW) && (cnt_q == CW'(ON_CYC - 1));
  assign boundary = en_i && show_end && (idx_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    zrun_d  = zrun_q;
    frame_d = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          idx_d   = IW'(DIGITS - 1);
          cnt_d   = '0;
          zrun_d  = lz_en_i;
        end
        GAP: begin
          if (cnt_q == CW'(GAP_CYC - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHOW: begin
          if (show_end) begin
            state_d = GAP;
            cnt_d   = '0;
            if (idx_q == '0) begin
              idx_d   = IW'(DIGITS - 1);
              zrun_d  = lz_en_i;
              frame_d = 1'b1;
            end else begin
              idx_d  = idx_q - IW'(1);
              zrun_d = zrun_q & (cur_nib == 4'd0);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A LOAD that lands exactly on the boundary bypasses staging so it is not lost behind stale pending data.
  always_comb begin
    shadow_d = shadow_q;
    stage_d  = stage_q;
    pend_d   = pend_q;
    if (state_q == IDLE) begin
      if (load_i) shadow_d = data_i;
    end else if (boundary) begin
      if (load_i)      shadow_d = data_i;
      else if (pend_q) shadow_d = stage_q;
      pend_d = 1'b0;
    end else if (load_i) begin
      stage_d = data_i;
      pend_d  = 1'b1;
    end
  end

  assign nxt_nib = shadow_d[{idx_d, 2'b00} +: 4];

  always_comb begin
    dcba_d = 4'd0;
    lt_d   = 1'b1;
    bi_d   = 1'b0;
    rbi_d  = 1'b1;
    if (state_d == SHOW) begin
      dcba_d = nxt_nib;
      bi_d   = ~blank_i;
      lt_d   = ~lt_req_i;
      rbi_d  = ~(zrun_d & (nxt_nib == 4'd0) & (idx_d != '0));
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign dig_d[gi] = ~((state_d == SHOW) && (idx_d == IW'(gi)));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= IW'(DIGITS - 1);
      zrun_q   <= 1'b0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      stage_q  <= '0;
      dcba_q   <= 4'd0;
      lt_q     <= 1'b1;
      bi_q     <= 1'b0;
      rbi_q    <= 1'b1;
      frame_q  <= 1'b0;
      dig_q    <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      zrun_q   <= zrun_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      stage_q  <= stage_d;
      dcba_q   <= dcba_d;
      lt_q     <= lt_d;
      bi_q     <= bi_d;
      rbi_q    <= rbi_d;
      frame_q  <= frame_d;
      dig_q    <= dig_d;
    end
  end

  assign {d_o, c_o, b_o, a_o} = dcba_q;
  assign lt_o    = lt_q;
  assign bi_o    = bi_q;
  assign rbi_o   = rbi_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DIGITS=4, ON_CYC=8, GAP_CYC=2.
// The reference model tracks the scan position within a 40-clock frame arithmetically, together with the frame data.
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, load = 1'b0, lz = 1'b0, ltr = 1'b0, blank = 1'b0;
  logic [15:0] data = '0;
  logic        d_o, c_o, b_o, a_o, lt_o, bi_o, rbi_o, frame_o;
  logic [3:0]  dig_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_run;
  int          m_pos;
  bit          m_lz;
  bit          m_pend;
  bit          m_frame;
  logic [15:0] m_shadow, m_stage;

  seg7_scan_ctrl #(.DIGITS(4), .ON_CYC(8), .GAP_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .data_i(data),
    .lz_en_i(lz), .lt_req_i(ltr), .blank_i(blank),
    .d_o(d_o), .c_o(c_o), .b_o(b_o), .a_o(a_o),
    .lt_o(lt_o), .bi_o(bi_o), .rbi_o(rbi_o), .dig_o(dig_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_lz = 0; m_pend = 0; m_frame = 0;
    m_shadow = '0; m_stage = '0;
  endtask

  task automatic check_reset();
    chk("rst_dig", dig_o, 4'hF);
    chk("rst_bi", bi_o, 1'b0);
    chk("rst_lt", lt_o, 1'b1);
    chk("rst_rbi", rbi_o, 1'b1);
    chk("rst_dcba", {d_o, c_o, b_o, a_o}, 4'h0);
    chk("rst_frame", frame_o, 1'b0);
  endtask

  task automatic check_outputs();
    int d;
    bit supp;
    logic [3:0] nib;
    chk("frame", frame_o, m_frame);
    if (!m_run) begin
      chk("idle_dig", dig_o, 4'hF);
      chk("idle_bi", bi_o, 1'b0);
      chk("idle_lt", lt_o, 1'b1);
      chk("idle_rbi", rbi_o, 1'b1);
      chk("idle_dcba", {d_o, c_o, b_o, a_o}, 4'h0);
    end else if ((m_pos % 10) < 2) begin
      chk("gap_dig", dig_o, 4'hF);
      chk("gap_bi", bi_o, 1'b0);
    end else begin
      d = 3 - m_pos / 10;
      nib = m_shadow[d*4 +: 4];
      // A digit is suppressed when it and every more significant digit are zero.
      supp = m_lz && (d != 0);
      for (int j = 3; j >= d; j--) if (m_shadow[j*4 +: 4] != 4'd0) supp = 0;
      chk("show_dig", dig_o, 4'hF & ~(4'h1 << d));
      chk("show_dcba", {d_o, c_o, b_o, a_o}, nib);
      chk("show_bi", bi_o, !blank);
      chk("show_lt", lt_o, !ltr);
      chk("show_rbi", rbi_o, !supp);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at that edge, then check the outputs.
  task automatic step();
    bit bnd;
    @(posedge clk);
    m_frame = 0;
    if (m_run) begin
      bnd = en && (((m_pos + 1) % 40) == 0);
      if (load && bnd) begin
        m_shadow = data; m_pend = 0;
      end else if (load) begin
        m_stage = data; m_pend = 1;
      end else if (bnd && m_pend) begin
        m_shadow = m_stage; m_pend = 0;
      end
      if (!en) m_run = 0;
      else begin
        m_pos = (m_pos + 1) % 40;
        if (bnd) begin m_frame = 1; m_lz = lz; end
      end
    end else begin
      if (load) m_shadow = data;
      if (en) begin m_run = 1; m_pos = 0; m_lz = lz; end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_load(input logic [15:0] v);
    $display("load data=%04h run=%0d pos=%0d", v, m_run, m_pos);
    data = v; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_pos == target) break;
      step();
    end
    chk("run_to_reached", (m_run && m_pos == target), 1'b1);
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
    return v;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset();
    rst = 1'b0;

    // Basic scan of 0042 with leading-zero suppression
    lz = 1'b1;
    do_load(16'h0042);
    en = 1'b1;
    repeat (85) step();

    // All-zero value, with and without suppression
    en = 1'b0; step();
    do_load(16'h0000);
    en = 1'b1;
    repeat (40) step();
    lz = 1'b0;
    repeat (45) step();

    // Mid-frame load must wait for the boundary
    en = 1'b0; step();
    lz = 1'b1;
    do_load(16'h0042);
    en = 1'b1;
    run_to(15);
    do_load(16'h1234);
    repeat (70) step();

    // Lamp test, then blanking
    ltr = 1'b1; repeat (40) step();
    ltr = 1'b0; blank = 1'b1; repeat (40) step();
    blank = 1'b0;

    // Scan disable during digit 1 and restart
    run_to(25);
    en = 1'b0; step(); step();
    en = 1'b1; repeat (45) step();

    // Randomized traffic
    repeat (1500) begin
      en    = ($urandom_range(0, 199) != 0);
      ltr   = ($urandom_range(0, 7) == 0);
      blank = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) lz = ~lz;
      load  = ($urandom_range(0, 29) == 0);
      data  = rnd_data();
      if (load) $display("load data=%04h run=%0d pos=%0d", data, m_run, m_pos);
      step();
    end
    load = 1'b0; ltr = 1'b0; blank = 1'b0; en = 1'b1;

    // Asynchronous reset in the middle of a SHOW slot
    run_to(14);
    #3 rst = 1'b1;
    #1 check_reset();
    @(posedge clk);
    #1 check_reset();
    rst = 1'b0;
    model_reset();
    lz = 1'b0; en = 1'b1;
    repeat (45) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
